// File: rtl/ntt_bu_scheduler.sv
// Address/zeta/mode sequencer for one butterfly unit doing a 256-point Kyber NTT or inverse NTT in place.
// Reads are issued for 128 cycles per layer, then the RAM+BU pipeline drains before the next layer starts.
module ntt_bu_scheduler #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned BU_LAT = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       is_ntt_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       mode_o,
  output logic [2:0] layer_o,
  output logic       rd_en_o,
  output logic [7:0] rd_addr_a_o,
  output logic [7:0] rd_addr_b_o,
  output logic [6:0] zeta_idx_o,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_a_o,
  output logic [7:0] wr_addr_b_o
);

  localparam int unsigned PIPE_LAT = RD_LAT + BU_LAT;
  localparam int unsigned DCW      = $clog2(PIPE_LAT + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(PIPE_LAT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]     state_q, state_n;
  logic [2:0]     layer_q, layer_n;
  logic [6:0]     bf_q, bf_n;
  logic [DCW-1:0] drain_q, drain_n;
  logic           mode_n;

  logic [3:0] shamt;
  logic [7:0] len;
  logic [6:0] grp;
  logic [7:0] offs;
  logic [7:0] addr_a, addr_b;
  logic [6:0] zeta_fwd, zeta_inv, zeta_n;

  // {valid, addr_a, addr_b}; rd_en_o/rd_addr_* feed stage 1, wr_* is the final stage
  logic [16:0] dly_q [1:PIPE_LAT-1];

  always_comb begin
    state_n = state_q;
    layer_n = layer_q;
    bf_n    = bf_q;
    drain_n = drain_q;
    mode_n  = mode_o;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_n = S_ISSUE;
          layer_n = '0;
          bf_n    = '0;
          drain_n = '0;
          mode_n  = is_ntt_i;
        end
      end
      S_ISSUE: begin
        if (bf_q == 7'd127) begin
          state_n = S_DRAIN;
          drain_n = '0;
        end else begin
          bf_n = bf_q + 7'd1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (layer_q == 3'd6) begin
            state_n = S_DONE;
          end else begin
            state_n = S_ISSUE;
            layer_n = layer_q + 3'd1;
            bf_n    = '0;
          end
        end else begin
          drain_n = drain_q + DCW'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_comb begin
    shamt    = mode_n ? (4'd7 - {1'b0, layer_n}) : ({1'b0, layer_n} + 4'd1);
    len      = mode_n ? (8'd128 >> layer_n) : (8'd2 << layer_n);
    grp      = bf_n >> shamt;
    offs     = {1'b0, bf_n} & (len - 8'd1);
    addr_a   = ({1'b0, grp} << (shamt + 4'd1)) | offs;
    addr_b   = addr_a + len;
    zeta_fwd = (7'd1 << layer_n) + grp;
    zeta_inv = (7'd127 >> layer_n) - grp;
    zeta_n   = mode_n ? zeta_fwd : zeta_inv;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      layer_q     <= '0;
      bf_q        <= '0;
      drain_q     <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      mode_o      <= 1'b0;
      layer_o     <= '0;
      rd_en_o     <= 1'b0;
      rd_addr_a_o <= '0;
      rd_addr_b_o <= '0;
      zeta_idx_o  <= '0;
      wr_en_o     <= 1'b0;
      wr_addr_a_o <= '0;
      wr_addr_b_o <= '0;
      for (int unsigned k = 1; k < PIPE_LAT; k++) begin
        dly_q[k] <= '0;
      end
    end else begin
      state_q <= state_n;
      layer_q <= layer_n;
      bf_q    <= bf_n;
      drain_q <= drain_n;
      busy_o  <= (state_n != S_IDLE);
      done_o  <= (state_n == S_DONE);
      mode_o  <= mode_n;
      layer_o <= layer_n;
      rd_en_o <= (state_n == S_ISSUE);
      if (state_n == S_ISSUE) begin
        rd_addr_a_o <= addr_a;
        rd_addr_b_o <= addr_b;
        zeta_idx_o  <= zeta_n;
      end else begin
        rd_addr_a_o <= '0;
        rd_addr_b_o <= '0;
        zeta_idx_o  <= '0;
      end
      dly_q[1] <= {rd_en_o, rd_addr_a_o, rd_addr_b_o};
      for (int unsigned k = 2; k < PIPE_LAT; k++) begin
        dly_q[k] <= dly_q[k-1];
      end
      {wr_en_o, wr_addr_a_o, wr_addr_b_o} <= dly_q[PIPE_LAT-1];
    end
  end

endmodule

// File: tb/tb_ntt_bu_scheduler.sv
// Directed bench for ntt_bu_scheduler: address/zeta vectors, timing, start/reset handling, and a model RAM
// driven by the scheduler compared against a textbook Kyber NTT/INTT loop nest.
module tb_ntt_bu_scheduler;
  localparam int Q  = 3329;
  localparam int PL = 7;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       is_ntt_i = 1'b0;
  logic       busy_o, done_o, mode_o, rd_en_o, wr_en_o;
  logic [2:0] layer_o;
  logic [7:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
  logic [6:0] zeta_idx_o;

  always #5 clk = ~clk;

  ntt_bu_scheduler #(.RD_LAT(1), .BU_LAT(6)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .is_ntt_i(is_ntt_i),
    .busy_o(busy_o), .done_o(done_o), .mode_o(mode_o), .layer_o(layer_o),
    .rd_en_o(rd_en_o), .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o),
    .zeta_idx_o(zeta_idx_o), .wr_en_o(wr_en_o),
    .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {int aa; int ba; int av; int bv; int z; int rel;} rd_t;
  rd_t pq[$];

  int ram[256];
  int gold[256];
  int ztab[128];
  logic [25:0] rec[896];

  function automatic int init_val(input int n);
    return (n * 37 + 11) % Q;
  endfunction

  task automatic bu(input logic ntt, input int a, input int b, input int zv, output int na, output int nb);
    int t;
    if (ntt) begin
      t  = (zv * b) % Q;
      na = (a + t) % Q;
      nb = (a - t + Q) % Q;
    end else begin
      na = (a + b) % Q;
      nb = (zv * ((b - a + Q) % Q)) % Q;
    end
  endtask

  task automatic golden(input logic ntt);
    int k, len, st, na, nb;
    for (int n = 0; n < 256; n++) gold[n] = init_val(n);
    if (ntt) begin
      k = 1;
      len = 128;
      while (len >= 2) begin
        st = 0;
        while (st < 256) begin
          for (int j = st; j < st + len; j++) begin
            bu(1'b1, gold[j], gold[j+len], ztab[k], na, nb);
            gold[j] = na;
            gold[j+len] = nb;
          end
          k++;
          st = st + 2 * len;
        end
        len = len / 2;
      end
    end else begin
      k = 127;
      len = 2;
      while (len <= 128) begin
        st = 0;
        while (st < 256) begin
          for (int j = st; j < st + len; j++) begin
            bu(1'b0, gold[j], gold[j+len], ztab[k], na, nb);
            gold[j] = na;
            gold[j+len] = nb;
          end
          k--;
          st = st + 2 * len;
        end
        len = len * 2;
      end
    end
  endtask

  task automatic vec(input string tag, input int idx, input int l, input int a, input int b, input int z);
    logic [25:0] exp;
    exp = {3'(l), 8'(a), 8'(b), 7'(z)};
    check(tag, 32'(rec[idx]), 32'(exp));
  endtask

  function automatic logic any_out();
    return |{busy_o, done_o, mode_o, layer_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, zeta_idx_o,
             wr_en_o, wr_addr_a_o, wr_addr_b_o};
  endfunction

  // One transform; hold_until/pulse_rel shape start_i, rst_rel aborts with an async reset.
  task automatic run(input logic ntt, input int hold_until, input int pulse_rel, input int rst_rel);
    int rel, rd_cnt, wr_cnt, done_cnt, done_rel, busy_cnt, first_rd, first_wr, last_rd;
    int gap_err, lat_err, mode_err, res_err, quiet, na, nb;
    logic aborted;
    rd_t e;
    for (int n = 0; n < 256; n++) ram[n] = init_val(n);
    golden(ntt);
    pq.delete();
    rel = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_rel = -1; busy_cnt = 0;
    first_rd = -1; first_wr = -1; last_rd = 0;
    gap_err = 0; lat_err = 0; mode_err = 0; res_err = 0; aborted = 1'b0;

    @(negedge clk);
    start_i = 1'b1;
    is_ntt_i = ntt;
    @(posedge clk);
    #1;
    if (hold_until == 0) start_i = 1'b0;
    is_ntt_i = ~ntt;
    check("busy_after_start", 32'(busy_o), 32'd1);

    for (int c = 0; c < 960; c++) begin
      @(negedge clk);
      rel++;
      if (rel == hold_until) start_i = 1'b0;
      if (pulse_rel != 0 && rel == pulse_rel) start_i = 1'b1;
      if (pulse_rel != 0 && rel == pulse_rel + 1) start_i = 1'b0;
      if (rst_rel != 0 && rel == rst_rel) begin
        aborted = 1'b1;
        break;
      end
      if (busy_o) busy_cnt++;
      if (busy_o && mode_o !== ntt) mode_err++;
      if (wr_en_o) begin
        if (first_wr < 0) first_wr = rel;
        if (pq.size() == 0) lat_err++;
        else begin
          e = pq.pop_front();
          if (rel - e.rel != PL || int'(wr_addr_a_o) != e.aa || int'(wr_addr_b_o) != e.ba) lat_err++;
          bu(ntt, e.av, e.bv, ztab[e.z], na, nb);
          ram[e.aa] = na;
          ram[e.ba] = nb;
        end
        wr_cnt++;
      end
      if (rd_en_o) begin
        if (first_rd < 0) first_rd = rel;
        if (rd_cnt > 0 && rd_cnt % 128 == 0 && rel - last_rd != PL + 1) gap_err++;
        if (rd_cnt % 128 != 0 && rel - last_rd != 1) gap_err++;
        last_rd = rel;
        if (rd_cnt < 896) rec[rd_cnt] = {layer_o, rd_addr_a_o, rd_addr_b_o, zeta_idx_o};
        e = '{int'(rd_addr_a_o), int'(rd_addr_b_o), ram[rd_addr_a_o], ram[rd_addr_b_o],
              int'(zeta_idx_o), rel};
        pq.push_back(e);
        rd_cnt++;
      end
      if (done_o) begin
        done_cnt++;
        if (done_rel < 0) done_rel = rel;
      end
    end

    if (aborted) begin
      #2;
      rst_i = 1'b1;
      #1;
      check("async_rst_outputs_zero", 32'(any_out()), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      start_i = 1'b0;
      quiet = 0;
      repeat (40) begin
        @(negedge clk);
        if (wr_en_o || rd_en_o || busy_o) quiet++;
      end
      check("quiet_after_rst", 32'(quiet), 32'd0);
    end else begin
      for (int n = 0; n < 256; n++) if (ram[n] != gold[n]) res_err++;
      check("first_rd_cycle", 32'(first_rd), 32'd1);
      check("first_wr_cycle", 32'(first_wr), 32'd8);
      check("rd_count", 32'(rd_cnt), 32'd896);
      check("wr_count", 32'(wr_cnt), 32'd896);
      check("done_count", 32'(done_cnt), 32'd1);
      check("done_cycle", 32'(done_rel), 32'd946);
      check("busy_cycles", 32'(busy_cnt), 32'd946);
      check("layer_gap_errs", 32'(gap_err), 32'd0);
      check("wr_latency_errs", 32'(lat_err), 32'd0);
      check("mode_errs", 32'(mode_err), 32'd0);
      check("pipe_left", 32'(pq.size()), 32'd0);
      check("result_errs", 32'(res_err), 32'd0);
      if (ntt) begin
        vec("ntt_l0_i0", 0, 0, 0, 128, 1);
        vec("ntt_l0_i127", 127, 0, 127, 255, 1);
        vec("ntt_l1_i63", 128 + 63, 1, 63, 127, 2);
        vec("ntt_l1_i64", 128 + 64, 1, 128, 192, 3);
        vec("ntt_l6_i5", 768 + 5, 6, 9, 11, 66);
        vec("ntt_l6_i127", 768 + 127, 6, 253, 255, 127);
      end else begin
        vec("intt_l0_i0", 0, 0, 0, 2, 127);
        vec("intt_l0_i1", 1, 0, 1, 3, 127);
        vec("intt_l0_i2", 2, 0, 4, 6, 126);
        vec("intt_l3_i20", 384 + 20, 3, 36, 52, 14);
        vec("intt_l6_i0", 768, 6, 0, 128, 1);
        vec("intt_l6_i127", 768 + 127, 6, 127, 255, 1);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 128; k++) ztab[k] = (k * 1753 + 17) % Q;
    #12;
    check("reset_outputs_zero", 32'(any_out()), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_outputs_zero", 32'(any_out()), 32'd0);

    run(1'b1, 0, 0, 0);
    run(1'b0, 0, 946, 0);
    run(1'b1, 900, 920, 0);
    run(1'b1, 0, 0, 450);
    run(1'b1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
